// File: rtl/ara_ring_hop_pkg.sv
// Shared types and helpers for the registered inter-cluster ring hop.
package ara_ring_hop_pkg;

  localparam int unsigned ElenWidth   = 64;
  localparam int unsigned DefDepth    = 2;
  localparam int unsigned DefCntWidth = 32;

  // Payload carried between adjacent clusters on the ring.
  typedef logic [ElenWidth-1:0] remote_data_t;

  // Circular-buffer pointer increment; depth need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ara_ring_hop_if.sv
// Valid/ready stream channel for one ring direction.
interface ara_ring_hop_if
  import ara_ring_hop_pkg::*;
#(
  parameter int unsigned DataWidth = ElenWidth
) ();

  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/ara_ring_hop_fifo.sv
// One direction of the ring hop: circular FIFO with flush, occupancy and transfer count.
// Both ready_o and valid_o derive from registered occupancy only (plus flush).
module ara_ring_hop_fifo
  import ara_ring_hop_pkg::*;
#(
  parameter int unsigned DataWidth = ElenWidth,
  parameter int unsigned Depth     = DefDepth,
  parameter int unsigned CntWidth  = DefCntWidth,
  localparam int unsigned OccWidth = $clog2(Depth + 1),
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OccWidth-1:0]  occ_o,
  output logic [CntWidth-1:0]  xfer_cnt_o
);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [OccWidth-1:0]  r_occ;
  logic [CntWidth-1:0]  r_cnt;

  logic                w_push;
  logic                w_pop;
  logic [PtrWidth-1:0] w_wptr_nxt;
  logic [PtrWidth-1:0] w_rptr_nxt;

  // Handshake decode and outputs; nothing here depends on valid_i/ready_i feeding back.
  always_comb begin
    ready_o    = (r_occ < OccWidth'(Depth)) && !flush_i;
    valid_o    = (r_occ != '0) && !flush_i;
    data_o     = r_mem[r_rptr];
    w_push     = valid_i && ready_o;
    w_pop      = valid_o && ready_i;
    w_wptr_nxt = PtrWidth'(ptr_next(32'(r_wptr), Depth));
    w_rptr_nxt = PtrWidth'(ptr_next(32'(r_rptr), Depth));
  end

  assign occ_o      = r_occ;
  assign xfer_cnt_o = r_cnt;

  // Storage, pointers, occupancy and transfer counter; flush beats push/pop but keeps the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
        r_cnt  <= r_cnt + CntWidth'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OccWidth'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - OccWidth'(1);
      end
    end
  end

  // A refused word must be held, unchanged, until accepted; a flush cycle releases it.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o && !flush_i) |=> valid_i);
  a_hold_data: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o && !flush_i) |=> $stable(data_i));
  a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_occ <= OccWidth'(Depth));

endmodule

// File: rtl/ara_ring_hop.sv
// Registered, elastic link between two adjacent clusters; l2r and r2l are independent FIFOs.
module ara_ring_hop
  import ara_ring_hop_pkg::*;
#(
  parameter int unsigned DataWidth = $bits(remote_data_t),
  parameter int unsigned Depth     = DefDepth,
  parameter int unsigned CntWidth  = DefCntWidth,
  localparam int unsigned OccWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  ara_ring_hop_if.slave       l2r_in,
  ara_ring_hop_if.master      l2r_out,
  ara_ring_hop_if.slave       r2l_in,
  ara_ring_hop_if.master      r2l_out,
  output logic [OccWidth-1:0] l2r_occ_o,
  output logic [OccWidth-1:0] r2l_occ_o,
  output logic [CntWidth-1:0] l2r_xfer_cnt_o,
  output logic [CntWidth-1:0] r2l_xfer_cnt_o
);

  ara_ring_hop_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .CntWidth  (CntWidth)
  ) u_l2r (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .data_i     (l2r_in.data),
    .valid_i    (l2r_in.valid),
    .ready_o    (l2r_in.ready),
    .data_o     (l2r_out.data),
    .valid_o    (l2r_out.valid),
    .ready_i    (l2r_out.ready),
    .occ_o      (l2r_occ_o),
    .xfer_cnt_o (l2r_xfer_cnt_o)
  );

  ara_ring_hop_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .CntWidth  (CntWidth)
  ) u_r2l (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .data_i     (r2l_in.data),
    .valid_i    (r2l_in.valid),
    .ready_o    (r2l_in.ready),
    .data_o     (r2l_out.data),
    .valid_o    (r2l_out.valid),
    .ready_i    (r2l_out.ready),
    .occ_o      (r2l_occ_o),
    .xfer_cnt_o (r2l_xfer_cnt_o)
  );

endmodule

// File: tb/tb_ara_ring_hop.sv
// Self-checking bench for ara_ring_hop: Depth-2 instance (a) for directed work,
// Depth-3 instance (b) for randomized full-duplex traffic against a scoreboard.
module tb_ara_ring_hop;
  import ara_ring_hop_pkg::*;

  localparam int unsigned Dw = 64;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  ara_ring_hop_if #(.DataWidth(Dw)) a_l2r_in (), a_l2r_out (), a_r2l_in (), a_r2l_out ();
  ara_ring_hop_if #(.DataWidth(Dw)) b_l2r_in (), b_l2r_out (), b_r2l_in (), b_r2l_out ();

  logic [1:0]  a_l2r_occ, a_r2l_occ, b_l2r_occ, b_r2l_occ;
  logic [31:0] a_l2r_cnt, a_r2l_cnt, b_l2r_cnt, b_r2l_cnt;

  ara_ring_hop #(.DataWidth(Dw), .Depth(2), .CntWidth(32)) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .l2r_in         (a_l2r_in),
    .l2r_out        (a_l2r_out),
    .r2l_in         (a_r2l_in),
    .r2l_out        (a_r2l_out),
    .l2r_occ_o      (a_l2r_occ),
    .r2l_occ_o      (a_r2l_occ),
    .l2r_xfer_cnt_o (a_l2r_cnt),
    .r2l_xfer_cnt_o (a_r2l_cnt)
  );

  ara_ring_hop #(.DataWidth(Dw), .Depth(3), .CntWidth(32)) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .l2r_in         (b_l2r_in),
    .l2r_out        (b_l2r_out),
    .r2l_in         (b_r2l_in),
    .r2l_out        (b_r2l_out),
    .l2r_occ_o      (b_l2r_occ),
    .r2l_occ_o      (b_r2l_occ),
    .l2r_xfer_cnt_o (b_l2r_cnt),
    .r2l_xfer_cnt_o (b_r2l_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush            = 1'b0;
    a_l2r_in.valid   = 1'b0;  a_l2r_in.data = '0;  a_l2r_out.ready = 1'b1;
    a_r2l_in.valid   = 1'b0;  a_r2l_in.data = '0;  a_r2l_out.ready = 1'b1;
    b_l2r_in.valid   = 1'b0;  b_l2r_in.data = '0;  b_l2r_out.ready = 1'b1;
    b_r2l_in.valid   = 1'b0;  b_r2l_in.data = '0;  b_r2l_out.ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One row = inputs for l2r of instance a this cycle and outputs expected before the edge.
  typedef struct {
    logic        v_i;
    logic [63:0] d_i;
    logic        rdy_i;
    logic        e_v;
    logic [63:0] e_d;
    logic        e_rdy;
    logic [1:0]  e_occ;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [12];

  // Watchdog: every wait in this bench is bounded by this limit.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ql [$];
    logic [63:0] qr [$];
    logic        lv, rv;
    logic [63:0] ld, rd;
    logic [31:0] l_seq, r_seq, l_pops, r_pops;

    vecs[0]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 64'h0,                  1'b1, 2'd0, 32'd0};
    vecs[1]  = '{1'b1, 64'hDEADBEEF_00000001,  1'b1, 1'b0, 64'h0,                  1'b1, 2'd0, 32'd0};
    vecs[2]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 64'hDEADBEEF_00000001,  1'b1, 2'd1, 32'd0};
    vecs[3]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 64'h0,                  1'b1, 2'd0, 32'd1};
    vecs[4]  = '{1'b1, 64'hA,                  1'b0, 1'b0, 64'h0,                  1'b1, 2'd0, 32'd1};
    vecs[5]  = '{1'b1, 64'hB,                  1'b0, 1'b1, 64'hA,                  1'b1, 2'd1, 32'd1};
    vecs[6]  = '{1'b1, 64'hC,                  1'b0, 1'b1, 64'hA,                  1'b0, 2'd2, 32'd1};
    vecs[7]  = '{1'b1, 64'hC,                  1'b0, 1'b1, 64'hA,                  1'b0, 2'd2, 32'd1};
    vecs[8]  = '{1'b1, 64'hC,                  1'b1, 1'b1, 64'hA,                  1'b0, 2'd2, 32'd1};
    vecs[9]  = '{1'b1, 64'hC,                  1'b1, 1'b1, 64'hB,                  1'b1, 2'd1, 32'd2};
    vecs[10] = '{1'b0, 64'h0,                  1'b1, 1'b1, 64'hC,                  1'b1, 2'd1, 32'd3};
    vecs[11] = '{1'b0, 64'h0,                  1'b1, 1'b0, 64'h0,                  1'b1, 2'd0, 32'd4};

    // Reset with random inputs for 3 cycles, release with inputs quiet.
    idle();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      flush          = 1'($urandom_range(0, 1));
      a_l2r_in.valid = 1'($urandom_range(0, 1));  a_l2r_in.data = {$urandom, $urandom};
      a_r2l_in.valid = 1'($urandom_range(0, 1));  a_r2l_in.data = {$urandom, $urandom};
      b_l2r_in.valid = 1'($urandom_range(0, 1));  b_l2r_in.data = {$urandom, $urandom};
      b_r2l_in.valid = 1'($urandom_range(0, 1));  b_r2l_in.data = {$urandom, $urandom};
      a_l2r_out.ready = 1'($urandom_range(0, 1)); a_r2l_out.ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rst_a_l2r_valid", 64'(a_l2r_out.valid), 64'd0);
    chk("rst_a_l2r_ready", 64'(a_l2r_in.ready),  64'd1);
    chk("rst_a_l2r_data",  a_l2r_out.data,       64'd0);
    chk("rst_a_l2r_occ",   64'(a_l2r_occ),       64'd0);
    chk("rst_a_l2r_cnt",   64'(a_l2r_cnt),       64'd0);
    chk("rst_a_r2l_valid", 64'(a_r2l_out.valid), 64'd0);
    chk("rst_a_r2l_ready", 64'(a_r2l_in.ready),  64'd1);
    chk("rst_a_r2l_data",  a_r2l_out.data,       64'd0);
    chk("rst_a_r2l_occ",   64'(a_r2l_occ),       64'd0);
    chk("rst_a_r2l_cnt",   64'(a_r2l_cnt),       64'd0);
    chk("rst_b_l2r_valid", 64'(b_l2r_out.valid), 64'd0);
    chk("rst_b_r2l_ready", 64'(b_r2l_in.ready),  64'd1);

    // Table: single word, then full + backpressure on l2r; r2l must stay idle throughout.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_l2r_in.valid  = vecs[i].v_i;
      a_l2r_in.data   = vecs[i].d_i;
      a_l2r_out.ready = vecs[i].rdy_i;
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(a_l2r_out.valid), 64'(vecs[i].e_v));
      if (vecs[i].e_v) chk($sformatf("vec%0d_data", i), a_l2r_out.data, vecs[i].e_d);
      chk($sformatf("vec%0d_ready", i), 64'(a_l2r_in.ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_occ", i),   64'(a_l2r_occ),      64'(vecs[i].e_occ));
      chk($sformatf("vec%0d_cnt", i),   64'(a_l2r_cnt),      64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_r2l_idle", i), 64'(a_r2l_out.valid), 64'd0);
    end

    // Streaming: 100 back-to-back words, each popped exactly one cycle after its push.
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      a_l2r_in.valid = (i < 100);
      a_l2r_in.data  = 64'(i);
      #1;
      if (i >= 1) begin
        chk($sformatf("stream%0d_valid", i), 64'(a_l2r_out.valid), 64'd1);
        chk($sformatf("stream%0d_data", i),  a_l2r_out.data,       64'(i - 1));
        chk($sformatf("stream%0d_occ", i),   64'(a_l2r_occ),       64'd1);
      end
    end
    @(negedge clk);
    a_l2r_in.valid = 1'b0;
    #1;
    chk("stream_cnt",   64'(a_l2r_cnt),       64'd100);
    chk("stream_drain", 64'(a_l2r_out.valid), 64'd0);

    // Asynchronous reset while full: outputs return without waiting for a clock edge.
    @(negedge clk);
    a_l2r_out.ready = 1'b0;
    a_l2r_in.valid  = 1'b1;  a_l2r_in.data = 64'h5;
    @(negedge clk);
    a_l2r_in.data   = 64'h6;
    @(negedge clk);
    a_l2r_in.valid  = 1'b0;
    #1;
    chk("arst_pre_occ", 64'(a_l2r_occ), 64'd2);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(a_l2r_out.valid), 64'd0);
    chk("arst_ready", 64'(a_l2r_in.ready),  64'd1);
    chk("arst_occ",   64'(a_l2r_occ),       64'd0);
    chk("arst_cnt",   64'(a_l2r_cnt),       64'd0);
    chk("arst_data",  a_l2r_out.data,       64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Flush on r2l: one word through, two stored, then flush with valid and ready high.
    @(negedge clk);
    a_r2l_in.valid = 1'b1;  a_r2l_in.data = 64'h11;
    @(negedge clk);
    a_r2l_in.valid = 1'b0;
    #1;
    chk("fl_first_data", a_r2l_out.data, 64'h11);
    @(negedge clk);
    a_r2l_out.ready = 1'b0;
    a_r2l_in.valid  = 1'b1;  a_r2l_in.data = 64'h22;
    #1;
    chk("fl_cnt_before", 64'(a_r2l_cnt), 64'd1);
    @(negedge clk);
    a_r2l_in.data = 64'h33;
    @(negedge clk);
    flush           = 1'b1;
    a_r2l_in.data   = 64'h44;
    a_r2l_out.ready = 1'b1;
    #1;
    chk("fl_ready_during", 64'(a_r2l_in.ready),  64'd0);
    chk("fl_valid_during", 64'(a_r2l_out.valid), 64'd0);
    chk("fl_occ_during",   64'(a_r2l_occ),       64'd2);
    @(negedge clk);
    flush          = 1'b0;
    a_r2l_in.valid = 1'b0;
    #1;
    chk("fl_occ_after",   64'(a_r2l_occ),       64'd0);
    chk("fl_valid_after", 64'(a_r2l_out.valid), 64'd0);
    chk("fl_ready_after", 64'(a_r2l_in.ready),  64'd1);
    chk("fl_cnt_after",   64'(a_r2l_cnt),       64'd1);
    chk("fl_rptr_reset",  a_r2l_out.data,       64'h33);
    @(negedge clk);
    a_r2l_in.valid = 1'b1;  a_r2l_in.data = 64'h55;
    @(negedge clk);
    a_r2l_in.valid = 1'b0;
    #1;
    chk("fl_post_valid", 64'(a_r2l_out.valid), 64'd1);
    chk("fl_post_data",  a_r2l_out.data,       64'h55);
    @(negedge clk);
    #1;
    chk("fl_post_empty", 64'(a_r2l_out.valid), 64'd0);
    chk("fl_post_cnt",   64'(a_r2l_cnt),       64'd2);

    // Random full-duplex traffic on the Depth-3 instance against per-direction queues.
    do_reset();
    lv = 1'b0;  rv = 1'b0;  ld = '0;  rd = '0;
    l_seq = '0;  r_seq = '0;  l_pops = '0;  r_pops = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!lv) begin
        lv = ($urandom_range(0, 3) != 0);
        ld = {32'hA5A5_0000, l_seq};
      end
      if (!rv) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = {32'h5A5A_0000, r_seq};
      end
      b_l2r_in.valid  = lv;  b_l2r_in.data = ld;
      b_r2l_in.valid  = rv;  b_r2l_in.data = rd;
      b_l2r_out.ready = ($urandom_range(0, 2) != 0);
      b_r2l_out.ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_l2r_occ",   64'(b_l2r_occ),       64'(ql.size()));
      chk("rnd_r2l_occ",   64'(b_r2l_occ),       64'(qr.size()));
      chk("rnd_l2r_valid", 64'(b_l2r_out.valid), 64'(ql.size() != 0));
      chk("rnd_r2l_valid", 64'(b_r2l_out.valid), 64'(qr.size() != 0));
      if (b_l2r_out.valid && b_l2r_out.ready && ql.size() != 0) begin
        chk("rnd_l2r_order", b_l2r_out.data, ql.pop_front());
        l_pops++;
      end
      if (b_r2l_out.valid && b_r2l_out.ready && qr.size() != 0) begin
        chk("rnd_r2l_order", b_r2l_out.data, qr.pop_front());
        r_pops++;
      end
      if (lv && b_l2r_in.ready) begin
        ql.push_back(ld);
        l_seq++;
        lv = 1'b0;
      end
      if (rv && b_r2l_in.ready) begin
        qr.push_back(rd);
        r_seq++;
        rv = 1'b0;
      end
    end
    @(negedge clk);
    b_l2r_in.valid  = 1'b0;  b_r2l_in.valid  = 1'b0;
    b_l2r_out.ready = 1'b0;  b_r2l_out.ready = 1'b0;
    #1;
    chk("rnd_l2r_cnt",     64'(b_l2r_cnt), 64'(l_pops));
    chk("rnd_r2l_cnt",     64'(b_r2l_cnt), 64'(r_pops));
    chk("rnd_l2r_occ_end", 64'(b_l2r_occ), 64'(ql.size()));
    chk("rnd_r2l_occ_end", 64'(b_r2l_occ), 64'(qr.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ara_ring_hop.md
Name: ara_ring_hop

Overview:
- Registered, elastic link between two adjacent ara_macro instances on the inter-cluster ring. Inserted on every ring hop, including the wrap hop from cluster NrClusters-1 back to cluster 0.
- One instance carries two independent directions:
  - l2r: the left cluster's ring_data_r_o goes to the right cluster's ring_data_l_i.
  - r2l: the right cluster's ring_data_l_o goes to the left cluster's ring_data_r_i.
- Breaks all ring timing paths, valid, data and ready alike. Also gives a flush and per-direction occupancy and transfer counters for debug.

Parameters:
- DataWidth, 64, ring payload width; equals $bits(elen_t).
- Depth, 2, entries per direction, at least 2. Depth 2 is needed for full throughput with a registered ready.
- CntWidth, 32, width of the per-direction transfer counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  synchronous flush of both directions
- l2r_data_i  in  DataWidth  payload from left cluster
- l2r_valid_i  in  1  left cluster offers data
- l2r_ready_o  out  1  hop accepts l2r data
- l2r_data_o  out  DataWidth  payload to right cluster
- l2r_valid_o  out  1  hop offers data to right cluster
- l2r_ready_i  in  1  right cluster accepts
- r2l_data_i / r2l_valid_i / r2l_ready_o / r2l_data_o / r2l_valid_o / r2l_ready_i: same roles, from right cluster to left cluster
- l2r_occ_o, r2l_occ_o  out  $clog2(Depth+1)  current entry count
- l2r_xfer_cnt_o, r2l_xfer_cnt_o  out  CntWidth  output handshakes completed

Interface note: one clock; reset is asynchronous and active-high. The clock is clk_i, the reset is rst_i, and every flop resets asynchronously on rst_i high.

Behaviour:
- Reset values: all valid_o = 0, all ready_o = 1, data_o = 0, occ = 0, counters = 0, pointers = 0.
- Directions are fully independent. Everything below applies per direction.
- FIFO storage:
  - Circular buffer of Depth entries, with write pointer, read pointer and occupancy count.
  - Pointers wrap from Depth-1 to 0; Depth need not be a power of two.
- Push: valid_i && ready_o. The entry is written at the write pointer and the write pointer advances.
- Pop: valid_o && ready_i. The read pointer advances and the transfer counter increments.
- ready_o:
  - ready_o = (occ < Depth) && !flush_i.
  - It is a registered-state function only. There is no combinational path from ready_i or valid_i to ready_o.
- valid_o / data_o:
  - valid_o = (occ != 0) && !flush_i.
  - data_o = entry at the read pointer.
  - There is no combinational valid_i-to-valid_o path.
- Latency: a word pushed in cycle N is first visible on valid_o in cycle N+1, even when the FIFO is empty. There is no bypass.
- Throughput: one word per cycle sustained when ready_i is held high. occ stays at 1 in steady state.
- Order: strict FIFO; words are never reordered or duplicated.
- Simultaneous push and pop:
  - With 0 < occ < Depth, both happen and occ is unchanged.
  - At occ == Depth, only the pop happens, because ready_o was 0.
  - At occ == 0, only the push happens, because valid_o was 0.
- Backpressure: data_o stays stable while valid_o && !ready_i.
- Flush:
  - While flush_i is high, no push or pop is performed.
  - Next cycle: occ = 0 and pointers = 0. Stored data is discarded, not cleared.
  - Transfer counters are not affected.
  - Flush takes priority over any push or pop in the same cycle.
- Counter rules:
  - Transfer counters wrap modulo 2^CntWidth.
  - occ arithmetic saturates by construction: a push at full and a pop at empty are impossible.
- Reset in mid-operation: all content is lost and the outputs return immediately (asynchronously) to their reset values.
- Assertions (simulation only):
  - valid_i must not drop without a handshake, and data_i must stay stable while valid_i && !ready_o.
  - occ never exceeds Depth.

Decomposition:
- ara_pkg: remote_data_t (logic [$bits(elen_t)-1:0]) is moved into ara_pkg, so the cluster top and ara_macro share it.
- Sub-module ara_ring_hop_fifo: one direction (FIFO, flush, occupancy, transfer counter). It is instantiated twice in ara_ring_hop.
- The cluster top instantiates NrClusters ara_ring_hop instances. Instance i connects cluster i (left) to cluster (i+1) mod NrClusters (right).

Test Plan:
- Reset: assert rst_i for 3 cycles with random inputs, then release. Expect valid_o = 0, ready_o = 1, occ = 0, counters = 0, data_o = 0 in both directions.
- Single word: push l2r 0xDEADBEEF_00000001 in cycle 5 with ready_i = 1. Expect l2r_valid_o in cycle 6 with that data; l2r_xfer_cnt_o = 1 in cycle 7; r2l stays idle.
- Streaming: 100 back-to-back l2r words (values 0..99) with ready_i = 1. Expect 100 pops on consecutive cycles 1..100 after the first push, in order, and l2r_xfer_cnt_o = 100.
- Full and backpressure (Depth = 2): hold l2r_ready_i = 0 and push 0xA, then 0xB. Expect occ = 2 and ready_o = 0, with a third word 0xC held off. Raise ready_i. Expect outputs 0xA, 0xB, 0xC in order; ready_o returns to 1 in the cycle after the first pop.
- Flush: fill r2l with 2 words, then pulse flush_i together with valid_i and ready_i high. Expect no handshake in that cycle, occ = 0 next cycle, valid_o = 0, and the xfer counter unchanged.
- Wrap-around and full-duplex (Depth = 3): random valid/ready on both directions for 10000 cycles against a scoreboard. Expect zero loss or reorder, pointers wrapping through 2 to 0, and occ never above 3.
